// File: rtl/flag_branch_unit.sv
// Architectural [Z, V, N] flag register with a pending-write scoreboard and a
// conditional-branch resolver that stalls until flags are final, with ALU bypass.
module flag_branch_unit #(
  parameter int PC_WIDTH     = 16,
  parameter int OFFSET_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flag_op_issue,
  input  logic                    alu_done,
  input  logic [2:0]              alu_control,
  input  logic [2:0]              alu_flags,
  input  logic                    br_valid,
  input  logic [2:0]              br_cond,
  input  logic [PC_WIDTH-1:0]     br_pc,
  input  logic [OFFSET_WIDTH-1:0] br_offset,
  output logic                    br_ready,
  output logic                    br_resolved,
  output logic                    br_taken,
  output logic [PC_WIDTH-1:0]     br_target,
  output logic [2:0]              flags,
  output logic                    pend_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESOLVE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [2:0]          flags_q, flags_d;
  logic [1:0]          pend_q, pend_d;
  logic                pend_err_q, pend_err_d;
  logic                br_taken_q, br_taken_d;
  logic [PC_WIDTH-1:0] br_target_q, br_target_d;

  logic       alu_sets_flags;
  logic [2:0] eff_flags;
  logic       cond_ok;
  logic       accept;

  function automatic logic eval_cond(input logic [2:0] cond, input logic [2:0] f);
    logic z, v, n;
    {z, v, n} = f;
    case (cond)
      3'b000:  return !z;
      3'b001:  return z;
      3'b010:  return !z && !n;
      3'b011:  return n;
      3'b100:  return z || !n;
      3'b101:  return z || n;
      3'b110:  return v;
      default: return 1'b1;
    endcase
  endfunction

  // Target wraps modulo 2^PC_WIDTH; the offset is sign-extended to PC width.
  function automatic logic [PC_WIDTH-1:0] calc_target(
    input logic [PC_WIDTH-1:0]     pc,
    input logic [OFFSET_WIDTH-1:0] off,
    input logic                    taken
  );
    logic signed [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0]        add;
    off_ext = {{(PC_WIDTH-OFFSET_WIDTH){off[OFFSET_WIDTH-1]}}, off};
    add     = taken ? $unsigned(off_ext) : '0;
    return pc + PC_WIDTH'(1) + add;
  endfunction

  always_comb begin
    alu_sets_flags = alu_done && (alu_control <= 3'b100);
    eff_flags      = flags_q;
    if (alu_sets_flags) begin
      if (alu_control == 3'b010 || alu_control == 3'b011)
        eff_flags = {alu_flags[2], 2'b00};
      else
        eff_flags = alu_flags;
    end
    cond_ok = eval_cond(br_cond, eff_flags);
    // A flag_op_issue this cycle is younger than the branch, so it is ignored here.
    accept  = !rst && br_valid &&
              (br_cond == 3'b111 || pend_q == 2'd0 ||
               (pend_q == 2'd1 && alu_sets_flags));
  end

  always_comb begin
    flags_d     = eff_flags;
    pend_d      = pend_q;
    pend_err_d  = pend_err_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    if (flag_op_issue && !alu_sets_flags) begin
      if (pend_q == 2'd3) pend_err_d = 1'b1;
      else                pend_d     = pend_q + 2'd1;
    end else if (!flag_op_issue && alu_sets_flags) begin
      if (pend_q == 2'd0) pend_err_d = 1'b1;
      else                pend_d     = pend_q - 2'd1;
    end
    if (accept) begin
      br_taken_d  = cond_ok;
      br_target_d = calc_target(br_pc, br_offset, cond_ok);
    end
  end

  // Every state shares the same exits: accept resolves, a held request waits.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE, S_WAIT, S_RESOLVE: begin
        if (accept)        state_d = S_RESOLVE;
        else if (br_valid) state_d = S_WAIT;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flags_q     <= 3'b000;
      pend_q      <= 2'd0;
      pend_err_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      pend_q      <= pend_d;
      pend_err_q  <= pend_err_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign br_ready    = accept;
  assign br_resolved = (state_q == S_RESOLVE);
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;
  assign flags       = flags_q;
  assign pend_err    = pend_err_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed vector table, scenario sequences and
// randomized traffic, all checked against a behavioural model.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_op_issue, alu_done, br_valid;
  logic [2:0]  alu_control, alu_flags, br_cond;
  logic [15:0] br_pc;
  logic [8:0]  br_offset;
  logic        br_ready, br_resolved, br_taken, pend_err;
  logic [15:0] br_target;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  flag_branch_unit #(.PC_WIDTH(16), .OFFSET_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .flag_op_issue(flag_op_issue), .alu_done(alu_done),
    .alu_control(alu_control), .alu_flags(alu_flags), .br_valid(br_valid),
    .br_cond(br_cond), .br_pc(br_pc), .br_offset(br_offset), .br_ready(br_ready),
    .br_resolved(br_resolved), .br_taken(br_taken), .br_target(br_target),
    .flags(flags), .pend_err(pend_err)
  );

  int checks = 0;
  int errors = 0;
  logic s_ready;

  // Reference model state
  logic [2:0]  m_flags;
  int          m_pend;
  logic        m_err, m_res, m_taken;
  logic [15:0] m_target;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_flag_op(input logic [2:0] c);
    return c inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  endfunction

  function automatic logic [2:0] model_eff_flags();
    if (alu_done && is_flag_op(alu_control)) begin
      if (alu_control == 3'd2 || alu_control == 3'd3) return {alu_flags[2], 2'b00};
      return alu_flags;
    end
    return m_flags;
  endfunction

  function automatic bit model_taken(input logic [2:0] cond, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (cond)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic model_ready();
    if (rst || !br_valid) return 1'b0;
    return (br_cond == 3'd7) || (m_pend == 0) ||
           (m_pend == 1 && alu_done && is_flag_op(alu_control));
  endfunction

  task automatic model_step(input logic rdy);
    int np, off, tgt;
    bit tk;
    if (rst) begin
      m_flags = 3'b000; m_pend = 0; m_err = 1'b0;
      m_res = 1'b0; m_taken = 1'b0; m_target = 16'h0000;
      return;
    end
    m_res = rdy;
    if (rdy) begin
      tk  = model_taken(br_cond, model_eff_flags());
      off = (int'(br_offset) >= 256) ? int'(br_offset) - 512 : int'(br_offset);
      tgt = int'(br_pc) + 1 + (tk ? off : 0);
      m_taken  = tk;
      m_target = 16'(tgt & 32'hFFFF);
    end
    m_flags = model_eff_flags();
    np = m_pend + (flag_op_issue ? 1 : 0) - ((alu_done && is_flag_op(alu_control)) ? 1 : 0);
    if (np > 3) begin np = 3; m_err = 1'b1; end
    if (np < 0) begin np = 0; m_err = 1'b1; end
    m_pend = np;
  endtask

  task automatic cycle();
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = model_ready();
    s_ready = br_ready;
    chk("br_ready", {31'd0, br_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    model_step(exp_rdy);
    #1;
    chk("flags", {29'd0, flags}, {29'd0, m_flags});
    chk("pend_err", {31'd0, pend_err}, {31'd0, m_err});
    chk("br_resolved", {31'd0, br_resolved}, {31'd0, m_res});
    chk("br_taken", {31'd0, br_taken}, {31'd0, m_taken});
    chk("br_target", {16'd0, br_target}, {16'd0, m_target});
  endtask

  task automatic clr();
    rst = 1'b0; flag_op_issue = 1'b0; alu_done = 1'b0; alu_control = 3'd0;
    alu_flags = 3'd0; br_valid = 1'b0; br_cond = 3'd0; br_pc = 16'd0; br_offset = 9'd0;
  endtask

  // Issue and complete a flag op in the same cycle so pending stays balanced.
  task automatic set_flags(input logic [2:0] ctl, input logic [2:0] f);
    clr();
    flag_op_issue = 1'b1; alu_done = 1'b1; alu_control = ctl; alu_flags = f;
    cycle();
    clr();
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [2:0]  cond;
    logic [15:0] pc;
    logic [8:0]  off;
    logic        exp_taken;
    logic [15:0] exp_target;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic        hold;
    logic [2:0]  h_cond;
    logic [15:0] h_pc;
    logic [8:0]  h_off;

    vecs[0] = '{3'b000, 3'd0, 16'h0010, 9'h004, 1'b1, 16'h0015};
    vecs[1] = '{3'b100, 3'd1, 16'h0010, 9'h004, 1'b1, 16'h0015};
    vecs[2] = '{3'b000, 3'd2, 16'h0100, 9'h1FC, 1'b1, 16'h00FD};
    vecs[3] = '{3'b001, 3'd2, 16'h0100, 9'h1FC, 1'b0, 16'h0101};
    vecs[4] = '{3'b001, 3'd3, 16'h0010, 9'h100, 1'b1, 16'hFF11};
    vecs[5] = '{3'b001, 3'd4, 16'h0200, 9'h0FF, 1'b0, 16'h0201};
    vecs[6] = '{3'b000, 3'd5, 16'h0200, 9'h0FF, 1'b0, 16'h0201};
    vecs[7] = '{3'b010, 3'd6, 16'h0200, 9'h0FF, 1'b1, 16'h0300};
    vecs[8] = '{3'b000, 3'd7, 16'hFFF0, 9'h020, 1'b1, 16'h0011};
    vecs[9] = '{3'b011, 3'd1, 16'h0040, 9'h001, 1'b0, 16'h0041};

    clr();
    rst = 1'b1;
    m_flags = 3'b000; m_pend = 0; m_err = 1'b0;
    m_res = 1'b0; m_taken = 1'b0; m_target = 16'h0000;
    cycle();
    cycle();
    chk("reset_ready", {31'd0, s_ready}, 32'd0);
    chk("reset_flags", {29'd0, flags}, 32'd0);
    chk("reset_target", {16'd0, br_target}, 32'd0);
    clr();
    cycle();

    // Directed vector table
    foreach (vecs[i]) begin
      set_flags(3'd0, vecs[i].f);
      br_valid = 1'b1; br_cond = vecs[i].cond; br_pc = vecs[i].pc; br_offset = vecs[i].off;
      cycle();
      clr();
      chk($sformatf("vec%0d_resolved", i), {31'd0, br_resolved}, 32'd1);
      chk($sformatf("vec%0d_taken", i), {31'd0, br_taken}, {31'd0, vecs[i].exp_taken});
      chk($sformatf("vec%0d_target", i), {16'd0, br_target}, {16'd0, vecs[i].exp_target});
    end
    cycle();
    chk("hold_resolved", {31'd0, br_resolved}, 32'd0);
    chk("hold_target", {16'd0, br_target}, 32'h0041);

    // EQ after ADD flags 101
    set_flags(3'd0, 3'b101);
    br_valid = 1'b1; br_cond = 3'd1; br_pc = 16'h0010; br_offset = 9'h004;
    cycle();
    clr();
    chk("eq_taken", {31'd0, br_taken}, 32'd1);
    chk("eq_target", {16'd0, br_target}, 32'h0015);

    // Stall until the SUB completes, then bypass its flags
    flag_op_issue = 1'b1;
    cycle();
    clr();
    br_valid = 1'b1; br_cond = 3'd1; br_pc = 16'h0020; br_offset = 9'h005;
    cycle();
    chk("stall_ready", {31'd0, s_ready}, 32'd0);
    cycle();
    chk("stall_ready2", {31'd0, s_ready}, 32'd0);
    alu_done = 1'b1; alu_control = 3'd1; alu_flags = 3'b000;
    cycle();
    chk("bypass_ready", {31'd0, s_ready}, 32'd1);
    clr();
    chk("bypass_resolved", {31'd0, br_resolved}, 32'd1);
    chk("bypass_taken", {31'd0, br_taken}, 32'd0);
    chk("bypass_target", {16'd0, br_target}, 32'h0021);
    cycle();
    chk("single_pulse", {31'd0, br_resolved}, 32'd0);

    // XOR clears V and N
    set_flags(3'd0, 3'b011);
    set_flags(3'd3, 3'b100);
    chk("xor_flags", {29'd0, flags}, 32'b100);
    br_valid = 1'b1; br_cond = 3'd6; br_pc = 16'h0050; br_offset = 9'h010;
    cycle();
    clr();
    chk("ovf_taken", {31'd0, br_taken}, 32'd0);

    // UNCOND ignores pending, target wraps
    flag_op_issue = 1'b1;
    cycle();
    cycle();
    clr();
    br_valid = 1'b1; br_cond = 3'd7; br_pc = 16'hFFFF; br_offset = 9'h000;
    cycle();
    chk("uncond_ready", {31'd0, s_ready}, 32'd1);
    clr();
    chk("uncond_target", {16'd0, br_target}, 32'h0000);

    // Saturate the pending counter
    flag_op_issue = 1'b1;
    cycle();
    chk("no_err_at3", {31'd0, pend_err}, 32'd0);
    cycle();
    cycle();
    clr();
    chk("overflow_err", {31'd0, pend_err}, 32'd1);
    rst = 1'b1;
    cycle();
    clr();
    chk("rst_err", {31'd0, pend_err}, 32'd0);
    chk("rst_flags", {29'd0, flags}, 32'd0);

    // Reset abandons a stalled branch
    flag_op_issue = 1'b1;
    cycle();
    clr();
    br_valid = 1'b1; br_cond = 3'd3; br_pc = 16'h0123; br_offset = 9'h003;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    clr();
    cycle();
    chk("rst_no_pulse", {31'd0, br_resolved}, 32'd0);

    // Randomized traffic; requests are held until accepted
    hold = 1'b0; h_cond = 3'd0; h_pc = 16'd0; h_off = 9'd0;
    for (int n = 0; n < 400; n++) begin
      clr();
      rst           = ($urandom_range(0, 60) == 0);
      flag_op_issue = ($urandom_range(0, 2) == 0);
      alu_done      = ($urandom_range(0, 2) == 0);
      alu_control   = 3'($urandom_range(0, 7));
      alu_flags     = 3'($urandom_range(0, 7));
      if (!hold && $urandom_range(0, 1) == 1) begin
        hold   = 1'b1;
        h_cond = 3'($urandom_range(0, 7));
        h_pc   = 16'($urandom);
        h_off  = 9'($urandom);
      end
      br_valid = hold; br_cond = h_cond; br_pc = h_pc; br_offset = h_off;
      cycle();
      if (s_ready) hold = 1'b0;
    end

    clr();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Holds the architectural [Z, V, N] flag register written by the ALU and resolves conditional branches against it. It sits between decode and the ALU. It counts flag-setting operations that have been issued but not yet completed, and stalls branch requests until the flags they depend on are final. One ALU completion per cycle can be forwarded directly into a waiting branch. Each accepted branch produces a registered taken/target result one cycle later.

## Interface
- PC_WIDTH, 16, width of branch PC and target
- OFFSET_WIDTH, 9, width of the signed two's-complement branch offset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flag_op_issue  in  1  a flag-setting ALU op (control 000–100) entered execute this cycle
- alu_done  in  1  ALU completed an op this cycle; alu_flags/alu_control valid
- alu_control  in  3  opcode of completing op (000 ADD, 001 SUB, 010 NAND, 011 XOR, 100 INC, 101–111 shifts)
- alu_flags  in  3  [Z, V, N] produced by completing op
- br_valid  in  1  branch request; br_cond/br_pc/br_offset must hold stable until accepted
- br_cond  in  3  condition code
- br_pc  in  PC_WIDTH  PC of branch instruction
- br_offset  in  OFFSET_WIDTH  signed offset
- br_ready  out  1  combinational; request accepted this cycle when br_valid & br_ready
- br_resolved  out  1  registered one-cycle pulse, one cycle after acceptance
- br_taken  out  1  registered, valid with br_resolved
- br_target  out  PC_WIDTH  registered, valid with br_resolved
- flags  out  3  registered architectural [Z, V, N]
- pend_err  out  1  sticky: pending counter overflow or underflow

## Operation
- Flag write on alu_done:
  - ADD/SUB/INC (000, 001, 100): write all of Z, V, N.
  - NAND/XOR (010, 011): write Z; clear V and N.
  - Shifts (101–111): no flag write, no counter effect.
- Pending counter, 2 bits (0–3):
  - Increments on flag_op_issue.
  - Decrements on alu_done with a flag-setting control.
  - Both in the same cycle: unchanged.
  - Increment at 3 or decrement at 0: counter holds and pend_err sets. pend_err clears only on rst.
- Effective flags for evaluation:
  - Normally the registered flags.
  - When alu_done carries a flag-setting op in the same cycle, the merged new value is used instead (bypass).
- br_ready = !rst & br_valid & one of:
  - br_cond == 111;
  - pending == 0;
  - pending == 1 and alu_done carries a flag-setting op this cycle.
- A flag_op_issue in the acceptance cycle is younger than the branch and does not affect it.
- FSM states:
  - IDLE: no request. br_valid & br_ready → RESOLVE; br_valid & !br_ready → WAIT.
  - WAIT: stalled. br_ready → RESOLVE.
  - RESOLVE: outputs presented. br_valid & br_ready → RESOLVE (back-to-back); br_valid only → WAIT; else → IDLE.
- Conditions (Z, V, N = effective flags):
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: Z | N
  - 110 OVF: V
  - 111 UNCOND: 1
- Target:
  - Taken: br_pc + 1 + sign_extend(br_offset), truncated modulo 2^PC_WIDTH; wrap-around is silent.
  - Not taken: br_pc + 1.

## Timing
- Reset values: flags 000, pending 0, FSM IDLE, br_resolved 0, br_taken 0, br_target 0, pend_err 0. br_ready is 0 while rst is high.
- rst mid-operation:
  - Any WAIT or RESOLVE state is abandoned; no br_resolved pulse follows.
  - The pending count is discarded.
- Latency:
  - Flags are visible on the `flags` output the cycle after alu_done.
  - Branch results are valid the cycle after acceptance.
  - A stalled branch is accepted in the same cycle as its resolving alu_done (zero-cycle bypass).
- br_resolved is high for exactly one cycle per accepted branch. Back-to-back acceptance gives consecutive pulses.
- br_taken and br_target hold their last values when br_resolved is 0.

## Test plan
- Reset, then alu_done with ADD flags 101, then br_cond=001, br_pc=0x0010, br_offset=+4 → next cycle br_resolved=1, br_taken=1, br_target=0x0015.
- flag_op_issue at cycle 0, br_valid with EQ at cycle 1 → br_ready=0. At cycle 3, alu_done with SUB flags 000 → br_ready=1 that cycle; next cycle br_taken=0, br_target=br_pc+1.
- Flags 011 (V, N set), then alu_done with XOR flags 100 → flags=100. Then OVF branch → not taken.
- br_pc=0xFFFF, offset=+0 with UNCOND while pending=2 → accepted immediately; br_target=0x0000.
- Four flag_op_issue pulses with no done → pending stays 3 and pend_err=1. rst → pend_err=0, flags=000.
- Branch stalled in WAIT, rst asserted → no br_resolved; br_ready=0 during rst.
